preamble_detect_v2: RTL

Parametrised successor to the LMS DSP preamble detector. It sits between the RX sample FIFO write port and the host-bound FIFO.
- Computes a per-sample L1 magnitude |I|+|Q|.
- Keeps a moving sum over a runtime-selectable window.
- On threshold crossing, gates a configurable burst of samples through to the output.
- Adds over the previous generation: retrigger mode, post-burst holdoff, warm-up qualification, parametrised widths, and a state/trigger-count debug view.

---
 rtl/preamble_detect_pkg.sv | 23 ++
 rtl/pd_mag_delay.sv | 84 ++++++++
 rtl/preamble_detect_v2.sv | 130 +++++++++++++
 3 files changed

// File: rtl/preamble_detect_pkg.sv
// rtl/preamble_detect_pkg.sv - shared types and width helpers for preamble_detect_v2
package preamble_detect_pkg;

  // Encoding matches the debug_state port
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PASS    = 2'd1,
    ST_HOLDOFF = 2'd2
  } pd_state_e;

  // I occupies the low half of the word, Q starts at the high half
  localparam int I_LSB = 0;

  function automatic int q_lsb(input int word_w);
    return word_w / 2;
  endfunction

  // Magnitude is SAMPLE_W+1 bits; a window of up to 2^LEN_W-1 of them cannot overflow this
  function automatic int sum_w(input int sample_w, input int len_w);
    return sample_w + 1 + len_w;
  endfunction

endpackage

// File: rtl/pd_mag_delay.sv
// rtl/pd_mag_delay.sv - L1 magnitude, delay line and moving window sum
module pd_mag_delay
  import preamble_detect_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int LEN_W    = 6,
  localparam int MAG_W   = SAMPLE_W + 1,
  localparam int SUM_W   = sum_w(SAMPLE_W, LEN_W)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_in_valid,
  input  logic signed [SAMPLE_W-1:0] i_i,
  input  logic signed [SAMPLE_W-1:0] i_q,
  input  logic                       i_upd,
  input  logic                       i_clear,
  input  logic        [LEN_W-1:0]    i_len,
  output logic        [SUM_W-1:0]    o_sum,
  output logic        [SUM_W-1:0]    o_sum_next,
  output logic                       o_full_next
);

  logic signed [MAG_W-1:0] w_i_ext, w_q_ext;
  logic        [MAG_W-1:0] w_abs_i, w_abs_q, w_mag, w_old;
  logic        [MAG_W-1:0] r_mag;
  logic        [MAG_W-1:0] r_line [2**LEN_W];
  logic        [LEN_W-1:0] r_ptr, r_fill, w_fill_next;
  logic        [SUM_W-1:0] r_sum, w_sum_next;

  // Widen before negating so the most negative input maps to +2^(SAMPLE_W-1)
  assign w_i_ext = MAG_W'(i_i);
  assign w_q_ext = MAG_W'(i_q);
  assign w_abs_i = w_i_ext[MAG_W-1] ? -w_i_ext : w_i_ext;
  assign w_abs_q = w_q_ext[MAG_W-1] ? -w_q_ext : w_q_ext;
  assign w_mag   = w_abs_i + w_abs_q;
  assign w_old   = r_line[r_ptr - i_len];

  // Stage 1: capture magnitude of each valid input sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mag <= '0;
    else if (i_in_valid) r_mag <= w_mag;
  end

  // Delay line storage; contents before the window fills are never read
  always_ff @(posedge clk) begin
    if (i_upd) r_line[r_ptr] <= r_mag;
  end

  // Next window sum/fill; a clear restarts the window at the current sample
  always_comb begin
    w_sum_next  = r_sum;
    w_fill_next = r_fill;
    if (i_len == '0) begin
      w_sum_next  = '0;
      w_fill_next = '0;
    end else if (i_clear) begin
      w_sum_next  = SUM_W'(r_mag);
      w_fill_next = LEN_W'(1);
    end else if (r_fill == i_len) begin
      w_sum_next  = r_sum + SUM_W'(r_mag) - SUM_W'(w_old);
    end else begin
      w_sum_next  = r_sum + SUM_W'(r_mag);
      w_fill_next = r_fill + LEN_W'(1);
    end
  end

  // Stage 2: commit window state on each pipelined valid sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_fill <= '0;
      r_ptr  <= '0;
    end else if (i_upd) begin
      r_sum  <= w_sum_next;
      r_fill <= w_fill_next;
      r_ptr  <= r_ptr + LEN_W'(1);
    end
  end

  assign o_sum       = r_sum;
  assign o_sum_next  = w_sum_next;
  assign o_full_next = (i_len != '0) && (w_fill_next == i_len);

endmodule

// File: rtl/preamble_detect_v2.sv
// rtl/preamble_detect_v2.sv - moving-sum preamble detector gating sample bursts
module preamble_detect_v2
  import preamble_detect_pkg::*;
#(
  parameter int WORD_W   = 48,
  parameter int SAMPLE_W = 12,
  parameter int LEN_W    = 6,
  parameter int PASS_W   = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [WORD_W-1:0] fifo_in_wdata,
  input  logic              fifo_in_wrreq,
  output logic [WORD_W-1:0] fifo_out_wrdata,
  output logic              fifo_out_wrreq,
  input  logic              cfg_enable,
  input  logic              cfg_retrigger,
  input  logic [LEN_W-1:0]  cfg_filter_len,
  input  logic [PASS_W-1:0] cfg_passthrough_len,
  input  logic [PASS_W-1:0] cfg_holdoff_len,
  input  logic [31:0]       cfg_threshold,
  output logic [31:0]       debug_sum,
  output logic [31:0]       debug_count,
  output logic [1:0]        debug_state
);

  localparam int SUM_W = sum_w(SAMPLE_W, LEN_W);
  localparam int Q_LSB = q_lsb(WORD_W);
  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_PASS    = ST_PASS;
  localparam logic [1:0] S_HOLDOFF = ST_HOLDOFF;

  logic              r_s1_valid;
  logic [WORD_W-1:0] r_s1_word;
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [LEN_W-1:0]  r_len;
  logic [1:0]        r_state;
  logic [PASS_W-1:0] r_cnt, r_hcnt;
  logic [31:0]       r_count;
  logic [SUM_W-1:0]  w_sum, w_sum_next;
  logic              w_full_next, w_clear, w_hit, w_gate;
  logic [PASS_W-1:0] w_pass_load, w_cnt_after;

  pd_mag_delay #(
    .SAMPLE_W (SAMPLE_W),
    .LEN_W    (LEN_W)
  ) u_mag_delay (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .i_in_valid  (fifo_in_wrreq),
    .i_i         (fifo_in_wdata[I_LSB +: SAMPLE_W]),
    .i_q         (fifo_in_wdata[Q_LSB +: SAMPLE_W]),
    .i_upd       (r_s1_valid),
    .i_clear     (w_clear),
    .i_len       (cfg_filter_len),
    .o_sum       (w_sum),
    .o_sum_next  (w_sum_next),
    .o_full_next (w_full_next)
  );

  assign w_clear     = !cfg_enable || (cfg_filter_len != r_len);
  assign w_hit       = w_full_next && (32'(w_sum_next) >= cfg_threshold);
  assign w_pass_load = (cfg_passthrough_len == '0) ? PASS_W'(1) : cfg_passthrough_len;

  // Gate decision and the burst count left after this sample is output
  always_comb begin
    w_gate      = (r_state == S_PASS) || ((r_state == S_IDLE) && w_hit);
    w_cnt_after = r_cnt - PASS_W'(1);
    if ((r_state != S_PASS) || (cfg_retrigger && w_hit)) w_cnt_after = w_pass_load - PASS_W'(1);
  end

  // Stage 1: register the input word alongside its magnitude
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
    end else begin
      r_s1_valid <= fifo_in_wrreq;
      if (fifo_in_wrreq) r_s1_word <= fifo_in_wdata;
    end
  end

  // Stage 2: burst FSM, output gating and trigger counting
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_len       <= '0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hcnt      <= '0;
      r_count     <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_s1_valid) begin
        r_len      <= cfg_filter_len;
        r_out_data <= r_s1_word;
        if (!cfg_enable) begin
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end else if (r_state == S_HOLDOFF) begin
          r_hcnt <= r_hcnt - PASS_W'(1);
          if (r_hcnt == PASS_W'(1)) r_state <= S_IDLE;
        end else if (w_gate) begin
          r_out_valid <= 1'b1;
          r_cnt       <= w_cnt_after;
          if (r_state == S_IDLE) r_count <= r_count + 32'd1;
          if (w_cnt_after != '0) begin
            r_state <= S_PASS;
          end else if (cfg_holdoff_len == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_HOLDOFF;
            r_hcnt  <= cfg_holdoff_len;
          end
        end else begin
          r_state <= S_IDLE;
        end
      end
    end
  end

  assign fifo_out_wrdata = r_out_data;
  assign fifo_out_wrreq  = r_out_valid;
  assign debug_sum       = 32'(w_sum);
  assign debug_count     = r_count;
  assign debug_state     = r_state;

endmodule
